// File: rtl/turf_acknack_sender_if.sv
// ============================================================================
// Module      : turf_acknack_sender_if
// Description : Stream bundle for the TURF ack/nack sender. Carries the
//               16-bit ack/nack entry input, the outgoing UDP header and data
//               streams, and the incoming UDP reply header and data streams.
// Ports       : s_acknack_*  entry stream into the sender
//               m_udphdr_*   outgoing header {ip, port, length}
//               m_udpdata_*  outgoing fragment words
//               s_udphdr_*   reply header {ip, port, length}
//               s_udpdata_*  reply data
//               modport master : view taken by the sender
//               modport slave  : view taken by producer / UDP stack
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface turf_acknack_sender_if;
    logic [15:0] s_acknack_tdata;
    logic        s_acknack_tvalid;
    logic        s_acknack_tready;

    logic [63:0] m_udphdr_tdata;
    logic        m_udphdr_tvalid;
    logic        m_udphdr_tready;

    logic [63:0] m_udpdata_tdata;
    logic [7:0]  m_udpdata_tkeep;
    logic        m_udpdata_tlast;
    logic        m_udpdata_tvalid;
    logic        m_udpdata_tready;

    logic [63:0] s_udphdr_tdata;
    logic        s_udphdr_tvalid;
    logic        s_udphdr_tready;

    logic [63:0] s_udpdata_tdata;
    logic [7:0]  s_udpdata_tkeep;
    logic        s_udpdata_tlast;
    logic        s_udpdata_tvalid;
    logic        s_udpdata_tready;

    modport master (
        input  s_acknack_tdata, s_acknack_tvalid,
        output s_acknack_tready,
        output m_udphdr_tdata, m_udphdr_tvalid,
        input  m_udphdr_tready,
        output m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast, m_udpdata_tvalid,
        input  m_udpdata_tready,
        input  s_udphdr_tdata, s_udphdr_tvalid,
        output s_udphdr_tready,
        input  s_udpdata_tdata, s_udpdata_tkeep, s_udpdata_tlast, s_udpdata_tvalid,
        output s_udpdata_tready
    );

    modport slave (
        output s_acknack_tdata, s_acknack_tvalid,
        input  s_acknack_tready,
        input  m_udphdr_tdata, m_udphdr_tvalid,
        output m_udphdr_tready,
        input  m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast, m_udpdata_tvalid,
        output m_udpdata_tready,
        output s_udphdr_tdata, s_udphdr_tvalid,
        input  s_udphdr_tready,
        output s_udpdata_tdata, s_udpdata_tkeep, s_udpdata_tlast, s_udpdata_tvalid,
        input  s_udpdata_tready
    );
endinterface

`default_nettype wire

// File: rtl/turf_acknack_sender.sv
// ============================================================================
// Module      : turf_acknack_sender
// Description : Initiator side of the TURF ack/nack UDP protocol. Batches
//               16-bit ack/nack entries into 64-bit fragment words, sends
//               them as one UDP packet, waits for the single-word reply,
//               checks it against the last word sent and retransmits on
//               timeout or mismatch.
// Ports       : aclk, aresetn      clock, synchronous active-low reset
//               dest_ip_i          destination IP, sampled at batch close
//               dest_port_i        destination port, sampled at batch close
//               bus (master)       entry, UDP TX and UDP RX streams
//               busy_o             high whenever not idle
//               open_o             bit 62 of the last accepted reply
//               done_o             pulse: reply matched, batch complete
//               err_mismatch_o     pulse: reply did not match
//               err_timeout_o      pulse: no reply in time
//               err_fail_o         pulse: retries exhausted, batch dropped
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module turf_acknack_sender #(
    parameter logic [63:0] CHECK_BITS     = 64'h800000FF_FFF00000,
    parameter int          MAX_BATCH      = 8,
    parameter int          FLUSH_CYCLES   = 256,
    parameter int          TIMEOUT_CYCLES = 125000,
    parameter int          MAX_RETRY      = 3
) (
    input  wire logic                   aclk,
    input  wire logic                   aresetn,
    input  wire logic [31:0]            dest_ip_i,
    input  wire logic [15:0]            dest_port_i,
    turf_acknack_sender_if.master       bus,
    output logic                        busy_o,
    output logic                        open_o,
    output logic                        done_o,
    output logic                        err_mismatch_o,
    output logic                        err_timeout_o,
    output logic                        err_fail_o
);

    // Bit 62 carries the "open" flag in replies and never takes part in the
    // comparison.
    localparam logic [63:0] c_MY_CHECK = CHECK_BITS & ~(64'd1 << 62);

    localparam int c_NW = $clog2(MAX_BATCH + 1);
    localparam int c_FW = (FLUSH_CYCLES < 2)   ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam int c_TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_RW = (MAX_RETRY < 1)      ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [c_NW-1:0] c_MAX_N      = c_NW'(MAX_BATCH);
    localparam logic [c_NW-1:0] c_ONE_N      = c_NW'(1);
    localparam logic [c_FW-1:0] c_FLUSH_LAST = c_FW'(FLUSH_CYCLES - 1);
    localparam logic [c_FW-1:0] c_ONE_F      = c_FW'(1);
    localparam logic [c_TW-1:0] c_TMO        = c_TW'(TIMEOUT_CYCLES);
    localparam logic [c_TW-1:0] c_TMO_LAST   = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_ONE_T      = c_TW'(1);
    localparam logic [c_RW-1:0] c_RETRY_MAX  = c_RW'(MAX_RETRY);
    localparam logic [c_RW-1:0] c_ONE_R      = c_RW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COLLECT   = 3'd1,
        S_SEND_HDR  = 3'd2,
        S_SEND_DATA = 3'd3,
        S_WAIT_HDR  = 3'd4,
        S_WAIT_DATA = 3'd5,
        S_DROP      = 3'd6,
        S_DRAIN     = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [63:0]       r_buf [MAX_BATCH];
    logic [c_NW-1:0]   r_n;
    logic [c_NW-1:0]   r_idx;
    logic [c_FW-1:0]   r_flush;
    logic [c_TW-1:0]   r_timer;
    logic [c_RW-1:0]   r_retries;
    logic [7:0]        r_seq;
    logic [31:0]       r_dest_ip;
    logic [15:0]       r_dest_port;
    logic              r_pass;
    logic              r_open;
    logic              r_done;
    logic              r_err_mm;
    logic              r_err_to;
    logic              r_err_fail;
    logic              r_rdy_en;

    logic              w_acc_rdy;
    logic              w_accept;
    logic [63:0]       w_word;
    logic [c_NW-1:0]   w_n_m1;
    logic              w_fill_last;
    logic [63:0]       w_dout;
    logic [63:0]       w_last_word;
    logic              w_data_last;
    logic              w_timeout;
    logic              w_reply_ok;
    logic              w_hdr_match;
    logic              w_in_wait;
    logic [15:0]       w_len;

    logic              w_close;
    logic              w_hdr_done;
    logic              w_beat;
    logic              w_retry;
    logic              w_rearm;
    logic              w_pass_evt;
    logic              w_mm_evt;
    logic              w_to_evt;
    logic              w_fail_evt;

    // Length and ignored entry bits are not needed by this side.
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.s_acknack_tdata[14:12], bus.s_udphdr_tdata[15:0]};

    // ------------------------------------------------------------------
    // Datapath decode
    // ------------------------------------------------------------------
    assign w_acc_rdy   = r_rdy_en &&
                         ((r_state == S_IDLE) || ((r_state == S_COLLECT) && (r_n < c_MAX_N)));
    assign w_accept    = w_acc_rdy && bus.s_acknack_tvalid;
    assign w_word      = {bus.s_acknack_tdata[15], 1'b0, 22'd0, r_seq,
                          bus.s_acknack_tdata[11:0], 20'd0};
    assign w_n_m1      = r_n - c_ONE_N;
    assign w_fill_last = ((r_n + c_ONE_N) == c_MAX_N);
    assign w_data_last = (r_idx == w_n_m1);
    assign w_timeout   = (r_timer >= c_TMO_LAST);
    assign w_in_wait   = (r_state == S_WAIT_HDR) || (r_state == S_WAIT_DATA) ||
                         (r_state == S_DROP);
    assign w_hdr_match = (bus.s_udphdr_tdata[63:32] == r_dest_ip) &&
                         (bus.s_udphdr_tdata[31:16] == r_dest_port);
    assign w_reply_ok  = (bus.s_udpdata_tkeep == 8'hFF) &&
                         ((bus.s_udpdata_tdata & c_MY_CHECK) == (w_last_word & c_MY_CHECK));
    assign w_len       = {{(13 - c_NW){1'b0}}, r_n, 3'b000};

    always_comb begin
        w_dout      = '0;
        w_last_word = '0;
        for (int i = 0; i < MAX_BATCH; i++) begin
            if (r_idx == c_NW'(i)) w_dout = r_buf[i];
            if (w_n_m1 == c_NW'(i)) w_last_word = r_buf[i];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_close     = 1'b0;
        w_hdr_done  = 1'b0;
        w_beat      = 1'b0;
        w_retry     = 1'b0;
        w_rearm     = 1'b0;
        w_pass_evt  = 1'b0;
        w_mm_evt    = 1'b0;
        w_to_evt    = 1'b0;
        w_fail_evt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_close     = w_fill_last;
                    w_state_nxt = w_fill_last ? S_SEND_HDR : S_COLLECT;
                end
            end
            S_COLLECT: begin
                // An accept restarts the flush window, so an entry that
                // coincides with flush expiry is always kept in the batch.
                if (w_accept) begin
                    if (w_fill_last) begin
                        w_close     = 1'b1;
                        w_state_nxt = S_SEND_HDR;
                    end
                end else if (r_flush == c_FLUSH_LAST) begin
                    w_close     = 1'b1;
                    w_state_nxt = S_SEND_HDR;
                end
            end
            S_SEND_HDR: begin
                if (bus.m_udphdr_tready) begin
                    w_hdr_done  = 1'b1;
                    w_state_nxt = S_SEND_DATA;
                end
            end
            S_SEND_DATA: begin
                if (bus.m_udpdata_tready) begin
                    w_beat = 1'b1;
                    if (w_data_last) w_state_nxt = S_WAIT_HDR;
                end
            end
            S_WAIT_HDR: begin
                if (bus.s_udphdr_tvalid) begin
                    w_state_nxt = w_hdr_match ? S_WAIT_DATA : S_DROP;
                end else if (w_timeout) begin
                    w_to_evt = 1'b1;
                    w_retry  = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                if (bus.s_udpdata_tvalid) begin
                    if (w_reply_ok) begin
                        w_pass_evt = 1'b1;
                        if (bus.s_udpdata_tlast) w_state_nxt = S_IDLE;
                        else                     w_state_nxt = S_DRAIN;
                    end else begin
                        w_mm_evt = 1'b1;
                        if (bus.s_udpdata_tlast) w_retry     = 1'b1;
                        else                     w_state_nxt = S_DRAIN;
                    end
                end else if (w_timeout) begin
                    w_to_evt = 1'b1;
                    w_retry  = 1'b1;
                end
            end
            S_DROP: begin
                if (bus.s_udpdata_tvalid && bus.s_udpdata_tlast) w_state_nxt = S_WAIT_HDR;
            end
            S_DRAIN: begin
                if (bus.s_udpdata_tvalid && bus.s_udpdata_tlast) begin
                    if (r_pass) w_state_nxt = S_IDLE;
                    else        w_retry     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Retry check shared by timeout and mismatch exits.
        if (w_retry) begin
            if (r_retries < c_RETRY_MAX) begin
                w_rearm     = 1'b1;
                w_state_nxt = S_SEND_HDR;
            end else begin
                w_fail_evt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_n         <= '0;
            r_idx       <= '0;
            r_flush     <= '0;
            r_timer     <= '0;
            r_retries   <= '0;
            r_seq       <= '0;
            r_dest_ip   <= '0;
            r_dest_port <= '0;
            r_pass      <= 1'b0;
            r_open      <= 1'b0;
            r_done      <= 1'b0;
            r_err_mm    <= 1'b0;
            r_err_to    <= 1'b0;
            r_err_fail  <= 1'b0;
            r_rdy_en    <= 1'b0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_done     <= w_pass_evt;
            r_err_mm   <= w_mm_evt;
            r_err_to   <= w_to_evt;
            r_err_fail <= w_fail_evt;

            if (w_accept) r_n <= r_n + c_ONE_N;

            if (w_accept)                   r_flush <= '0;
            else if (r_state == S_COLLECT)  r_flush <= r_flush + c_ONE_F;

            if (w_close) begin
                r_dest_ip   <= dest_ip_i;
                r_dest_port <= dest_port_i;
                r_retries   <= '0;
            end

            if (w_hdr_done)  r_idx <= '0;
            else if (w_beat) r_idx <= r_idx + c_ONE_N;

            // Timer runs from the final data beat and keeps counting while
            // foreign replies are dropped.
            if (w_beat && w_data_last)            r_timer <= '0;
            else if (w_in_wait && r_timer < c_TMO) r_timer <= r_timer + c_ONE_T;

            if (w_rearm) r_retries <= r_retries + c_ONE_R;

            if ((r_state == S_WAIT_DATA) && bus.s_udpdata_tvalid) r_pass <= w_reply_ok;

            if (w_pass_evt) r_open <= bus.s_udpdata_tdata[62];

            if (w_pass_evt || w_fail_evt) begin
                r_seq <= r_seq + 8'd1;
                r_n   <= '0;
            end
        end
    end

    // Word buffer: contents are only meaningful below r_n, so no reset.
    always_ff @(posedge aclk) begin
        if (w_accept) begin
            for (int i = 0; i < MAX_BATCH; i++) begin
                if (r_n == c_NW'(i)) r_buf[i] <= w_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.s_acknack_tready = w_acc_rdy;

    assign bus.m_udphdr_tvalid  = (r_state == S_SEND_HDR);
    assign bus.m_udphdr_tdata   = {r_dest_ip, r_dest_port, w_len};

    assign bus.m_udpdata_tvalid = (r_state == S_SEND_DATA);
    assign bus.m_udpdata_tdata  = w_dout;
    assign bus.m_udpdata_tkeep  = 8'hFF;
    assign bus.m_udpdata_tlast  = w_data_last;

    assign bus.s_udphdr_tready  = !((r_state == S_WAIT_DATA) || (r_state == S_DROP) ||
                                    (r_state == S_DRAIN));
    assign bus.s_udpdata_tready = (r_state != S_WAIT_HDR);

    assign busy_o         = (r_state != S_IDLE);
    assign open_o         = r_open;
    assign done_o         = r_done;
    assign err_mismatch_o = r_err_mm;
    assign err_timeout_o  = r_err_to;
    assign err_fail_o     = r_err_fail;

endmodule

`default_nettype wire

// File: tb/tb_turf_acknack_sender.sv
// ============================================================================
// Module      : tb_turf_acknack_sender
// Description : Directed self-checking bench for turf_acknack_sender.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_turf_acknack_sender;

    localparam int TMO = 300;

    logic        aclk;
    logic        aresetn;
    logic [31:0] dest_ip;
    logic [15:0] dest_port;
    logic        busy;
    logic        open_f;
    logic        done_p;
    logic        mm_p;
    logic        to_p;
    logic        fail_p;

    turf_acknack_sender_if bus();

    turf_acknack_sender #(
        .CHECK_BITS     (64'h800000FF_FFF00000),
        .MAX_BATCH      (8),
        .FLUSH_CYCLES   (256),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (3)
    ) u_dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .dest_ip_i      (dest_ip),
        .dest_port_i    (dest_port),
        .bus            (bus),
        .busy_o         (busy),
        .open_o         (open_f),
        .done_o         (done_p),
        .err_mismatch_o (mm_p),
        .err_timeout_o  (to_p),
        .err_fail_o     (fail_p)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_done = 0;
    int n_mm   = 0;
    int n_to   = 0;
    int n_fail = 0;
    always @(posedge aclk) begin
        if (done_p === 1'b1) n_done++;
        if (mm_p   === 1'b1) n_mm++;
        if (to_p   === 1'b1) n_to++;
        if (fail_p === 1'b1) n_fail++;
    end

    int          total = 0;
    int          bad   = 0;
    int          stable_bad = 0;
    logic [63:0] rx [0:15];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Present one entry and hold tvalid until it is taken.
    task automatic push(input logic [15:0] d);
        int k;
        bus.s_acknack_tdata  = d;
        bus.s_acknack_tvalid = 1'b1;
        k = 0;
        while (!bus.s_acknack_tready && k < 50) begin tick(); k++; end
        chk("push_rdy", bus.s_acknack_tready, 1);
        tick();
    endtask

    task automatic wait_hdr(output logic [63:0] h, input int lim);
        int k;
        k = 0;
        while (!bus.m_udphdr_tvalid && k < lim) begin tick(); k++; end
        chk("hdr_valid", bus.m_udphdr_tvalid, 1);
        h = bus.m_udphdr_tdata;
        tick();
    endtask

    task automatic get_pkt(input bit rnd, input int stop_after, output int cnt, output bit got_last);
        logic [63:0] held_d;
        bit          held;
        bit          fin;
        int          k;
        cnt = 0; got_last = 0; held = 0; fin = 0; k = 0; held_d = '0;
        while (!fin && k < 300) begin
            bus.m_udpdata_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held && (!bus.m_udpdata_tvalid || bus.m_udpdata_tdata !== held_d)) stable_bad++;
            if (bus.m_udpdata_tvalid && bus.m_udpdata_tready) begin
                rx[cnt[3:0]] = bus.m_udpdata_tdata;
                cnt++;
                got_last = bus.m_udpdata_tlast;
                held = 0;
                if (got_last || cnt >= stop_after) fin = 1;
            end else if (bus.m_udpdata_tvalid) begin
                held   = 1;
                held_d = bus.m_udpdata_tdata;
            end
            tick();
            k++;
        end
        bus.m_udpdata_tready = 1'b1;
    endtask

    task automatic reply(input logic [31:0] ip, input logic [15:0] port,
                         input logic [63:0] d0, input int nb);
        int k;
        bus.s_udphdr_tdata  = {ip, port, 16'(nb * 8)};
        bus.s_udphdr_tvalid = 1'b1;
        k = 0;
        while (!bus.s_udphdr_tready && k < 50) begin tick(); k++; end
        chk("rhdr_rdy", bus.s_udphdr_tready, 1);
        tick();
        bus.s_udphdr_tvalid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            bus.s_udpdata_tdata  = (b == 0) ? d0 : 64'hFFFF0000_FFFF0000;
            bus.s_udpdata_tkeep  = 8'hFF;
            bus.s_udpdata_tlast  = (b == nb - 1);
            bus.s_udpdata_tvalid = 1'b1;
            k = 0;
            while (!bus.s_udpdata_tready && k < 50) begin tick(); k++; end
            chk("rdat_rdy", bus.s_udpdata_tready, 1);
            tick();
        end
        bus.s_udpdata_tvalid = 1'b0;
        bus.s_udpdata_tlast  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] h;
        int          cnt;
        int          k;
        int          d0, m0, t0, f0;
        bit          lst;

        aresetn              = 1'b0;
        dest_ip              = 32'hC0A80102;
        dest_port            = 16'h1234;
        bus.s_acknack_tdata  = '0;
        bus.s_acknack_tvalid = 1'b0;
        bus.m_udphdr_tready  = 1'b1;
        bus.m_udpdata_tready = 1'b1;
        bus.s_udphdr_tdata   = '0;
        bus.s_udphdr_tvalid  = 1'b0;
        bus.s_udpdata_tdata  = '0;
        bus.s_udpdata_tkeep  = '0;
        bus.s_udpdata_tlast  = 1'b0;
        bus.s_udpdata_tvalid = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_acc_rdy", bus.s_acknack_tready, 0);
        chk("rst_hvalid",  bus.m_udphdr_tvalid, 0);
        chk("rst_dvalid",  bus.m_udpdata_tvalid, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_open",    open_f, 0);
        aresetn = 1'b1;
        tick();
        chk("rel_acc_rdy", bus.s_acknack_tready, 1);

        // Full batch of 8, reply equals last word
        for (int i = 0; i < 8; i++) push(16'h8005 + 16'(i));
        bus.s_acknack_tvalid = 1'b0;
        chk("full_hdr_next", bus.m_udphdr_tvalid, 1);
        wait_hdr(h, 10);
        chk("full_hdr", h, {32'hC0A80102, 16'h1234, 16'h0040});
        get_pkt(0, 16, cnt, lst);
        chk("full_cnt",  64'(cnt), 8);
        chk("full_last", lst, 1);
        chk("full_w0",   rx[0], 64'h80000000_00500000);
        chk("full_w7",   rx[7], 64'h80000000_00C00000);
        d0 = n_done;
        reply(32'hC0A80102, 16'h1234, 64'h80000000_00C00000, 1);
        tick(); tick();
        chk("full_done", 64'(n_done - d0), 1);
        chk("full_idle", busy, 0);

        // Single entry closed by flush; reply with bit 62 set
        push(16'h0123);
        bus.s_acknack_tvalid = 1'b0;
        cnt = 0;
        while (!bus.m_udphdr_tvalid && cnt < 400) begin tick(); cnt++; end
        chk("flush_lat", 64'(cnt), 256);
        wait_hdr(h, 10);
        chk("flush_hdr", h, {32'hC0A80102, 16'h1234, 16'h0008});
        get_pkt(0, 16, cnt, lst);
        chk("flush_cnt", 64'(cnt), 1);
        chk("flush_w0",  rx[0], 64'h00000001_12300000);
        d0 = n_done;
        reply(32'hC0A80102, 16'h1234, 64'h40000001_12300000, 1);
        tick(); tick();
        chk("open_done", 64'(n_done - d0), 1);
        chk("open_set",  open_f, 1);

        // No reply: four identical packets, four timeouts, then fail
        t0 = n_to; f0 = n_fail;
        push(16'h8ABC);
        bus.s_acknack_tvalid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            wait_hdr(h, 1000);
            chk("tmo_hdr", h, {32'hC0A80102, 16'h1234, 16'h0008});
            get_pkt(0, 16, cnt, lst);
            chk("tmo_w", rx[0], 64'h80000002_ABC00000);
        end
        k = 0;
        while (n_fail == f0 && k < 1000) begin tick(); k++; end
        chk("tmo_count", 64'(n_to - t0), 4);
        chk("tmo_fail",  64'(n_fail - f0), 1);
        chk("tmo_idle",  busy, 0);

        // Wrong-port reply dropped, then correct reply
        push(16'h8001);
        bus.s_acknack_tvalid = 1'b0;
        wait_hdr(h, 400);
        get_pkt(0, 16, cnt, lst);
        chk("drop_w", rx[0], 64'h80000003_00100000);
        d0 = n_done; m0 = n_mm; t0 = n_to;
        reply(32'hC0A80102, 16'h9999, 64'h80000003_00100000, 2);
        tick(); tick();
        chk("drop_nodone", 64'(n_done - d0), 0);
        reply(32'hC0A80102, 16'h1234, 64'h80000003_00100000, 1);
        tick(); tick();
        chk("drop_done", 64'(n_done - d0), 1);
        chk("drop_nomm", 64'(n_mm - m0), 0);
        chk("drop_noto", 64'(n_to - t0), 0);
        chk("open_clr",  open_f, 0);

        // Wrong data: mismatch and immediate retransmit
        push(16'h8002);
        bus.s_acknack_tvalid = 1'b0;
        wait_hdr(h, 400);
        get_pkt(0, 16, cnt, lst);
        chk("mm_w", rx[0], 64'h80000004_00200000);
        d0 = n_done; m0 = n_mm;
        reply(32'hC0A80102, 16'h1234, 64'h80000004_00300000, 2);
        wait_hdr(h, 5);
        get_pkt(0, 16, cnt, lst);
        chk("mm_retx",  rx[0], 64'h80000004_00200000);
        chk("mm_pulse", 64'(n_mm - m0), 1);
        reply(32'hC0A80102, 16'h1234, 64'h80000004_00200000, 1);
        tick(); tick();
        chk("mm_done", 64'(n_done - d0), 1);

        // Random backpressure, then reset mid-packet
        for (int i = 0; i < 8; i++) push(16'h8010 + 16'(i));
        bus.s_acknack_tvalid = 1'b0;
        wait_hdr(h, 10);
        get_pkt(1, 4, cnt, lst);
        chk("rnd_cnt", 64'(cnt), 4);
        for (int i = 0; i < 4; i++)
            chk("rnd_w", rx[i], {32'h80000005, 12'h010 + 12'(i), 20'h0});
        chk("rnd_stable", 64'(stable_bad), 0);
        chk("pre_rst_dvalid", bus.m_udpdata_tvalid, 1);
        aresetn = 1'b0;
        tick();
        chk("mid_rst_dvalid",  bus.m_udpdata_tvalid, 0);
        chk("mid_rst_hvalid",  bus.m_udphdr_tvalid, 0);
        chk("mid_rst_busy",    busy, 0);
        chk("mid_rst_acc_rdy", bus.s_acknack_tready, 0);
        aresetn = 1'b1;
        tick();
        chk("post_rst_acc_rdy", bus.s_acknack_tready, 1);
        chk("post_rst_busy",    busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
